// File: rtl/sorter_pkg.sv
// Shared types for the streaming insertion sorter: FSM states, sort mode
// constants and the per-cell load-select encoding.
package sorter_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic MODE_ASC  = 1'b0;
  localparam logic MODE_DESC = 1'b1;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_NEW,
    SEL_NBR,
    SEL_SHIFT
  } sel_t;

endpackage

// File: rtl/stream_sorter_param_if.sv
// Input/output valid-ready stream bundle for stream_sorter_param.
// slave = sorter side, master = source/consumer side.
interface stream_sorter_param_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sort_cell.sv
// One sorter cell: data register plus valid bit, insertion compare output c
// and a hold/new/neighbour/shift load mux.
module sort_cell
  import sorter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins,
  input  logic             shift,
  input  logic             mode_q,
  input  logic [WIDTH-1:0] din,
  input  logic             c_prev,
  input  logic [WIDTH-1:0] d_prev,
  input  logic             v_prev,
  input  logic [WIDTH-1:0] d_next,
  input  logic             v_next,
  output logic             c,
  output logic [WIDTH-1:0] d,
  output logic             v
);

  logic [WIDTH-1:0] d_q;
  logic             v_q;
  sel_t             sel;

  // Strict compare keeps equal words in arrival order.
  always_comb begin
    c   = ~v_q | ((mode_q == MODE_DESC) ? (din > d_q) : (din < d_q));
    sel = SEL_HOLD;
    if (shift)              sel = SEL_SHIFT;
    else if (ins && c_prev) sel = SEL_NBR;
    else if (ins && c)      sel = SEL_NEW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else begin
      case (sel)
        SEL_SHIFT: begin d_q <= d_next; v_q <= v_next; end
        SEL_NBR:   begin d_q <= d_prev; v_q <= v_prev; end
        SEL_NEW:   begin d_q <= din;    v_q <= 1'b1;   end
        default:   ;
      endcase
    end
  end

  assign d = v_q ? d_q : '0;
  assign v = v_q;

endmodule

// File: rtl/stream_sorter_param.sv
// Streaming insertion sorter: DEPTH cells, asc/desc mode latched per batch,
// flush for partial batches. Optional macro SORTER_DEDUP_EN drops duplicates.
module stream_sorter_param
  import sorter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   flush,
  stream_sorter_param_if.slave   bus,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH*WIDTH-1:0] sorted_flat,
  output logic [DEPTH-1:0]       sorted_vld
`ifdef SORTER_DEDUP_EN
  ,
  output logic [WIDTH-1:0]       dup_cnt
`endif
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t                        state_q, state_d;
  logic   [CNT_W-1:0]            count_q;
  logic                          mode_q;
  logic   [DEPTH-1:0]            c, v, v_prev, v_next;
  logic   [DEPTH-1:0][WIDTH-1:0] d, d_prev, d_next;
  logic                          accept, flush_go, ins, pop, dup;

  assign accept   = bus.in_valid & bus.in_ready;
  assign flush_go = en & flush & (state_q == FILL) & (count_q != '0);
  assign ins      = accept & ~flush_go & ~dup;
  assign pop      = bus.out_valid & bus.out_ready;

  assign d_prev = {d[DEPTH-2:0], {WIDTH{1'b0}}};
  assign v_prev = {v[DEPTH-2:0], 1'b0};
  assign d_next = {{WIDTH{1'b0}}, d[DEPTH-1:1]};
  assign v_next = {1'b0, v[DEPTH-1:1]};

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    sort_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .ins    (ins),
      .shift  (pop),
      .mode_q (mode_q),
      .din    (bus.in_data),
      .c_prev (i == 0 ? 1'b0 : c[(i == 0) ? 0 : i-1]),
      .d_prev (d_prev[i]),
      .v_prev (v_prev[i]),
      .d_next (d_next[i]),
      .v_next (v_next[i]),
      .c      (c[i]),
      .d      (d[i]),
      .v      (v[i])
    );
  end

`ifdef SORTER_DEDUP_EN
  logic [DEPTH-1:0] match;
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      match[i] = v[i] && (d[i] == bus.in_data);
  end
  assign dup = |match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     dup_cnt <= '0;
    else if (state_q == DRAIN && state_d == FILL) dup_cnt <= '0;
    else if (accept && !flush_go && dup && dup_cnt != '1)
      dup_cnt <= dup_cnt + 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      FILL: begin
        bus.in_ready = en && (count_q < FULL);
        if (flush_go)                          state_d = DRAIN;
        else if (ins && count_q == FULL - ONE) state_d = DRAIN;
      end
      DRAIN: begin
        bus.out_valid = en && (count_q != '0);
        if (pop && count_q == ONE) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      count_q <= '0;
      mode_q  <= MODE_ASC;
    end else begin
      state_q <= state_d;
      if (ins)      count_q <= count_q + ONE;
      else if (pop) count_q <= count_q - ONE;
      if (accept && !flush_go && count_q == '0) mode_q <= mode;
    end
  end

  assign bus.out_data = d[0];
  assign count        = count_q;
  assign sorted_flat  = d;
  assign sorted_vld   = v;

endmodule

// File: doc/stream_sorter_param.md
Name: stream_sorter_param

Overview:
- Parametrised successor to sorting_top: a streaming insertion sorter with configurable WIDTH and DEPTH and run-time ascending/descending mode.
- Uses a valid/ready handshake on input and output. Supports a partial-batch flush.
- Sits between a data source (counter/stimulus or upstream FIFO) and a consumer. Exposes both a serial drain port and the full parallel sorted array.

Parameters:
- WIDTH, 32, bit width of each data word (unsigned compare).
- DEPTH, 16, number of sort cells (batch size), ≥2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  global enable; low freezes all handshakes and state.
- mode  input  1  0 = ascending, 1 = descending; latched on first accept of a batch.
- flush  input  1  one-cycle pulse: start draining a partial batch.
- in_valid  input  1  input word valid.
- in_ready  output  1  sorter can accept a word.
- in_data  input  WIDTH  input word.
- out_valid  output  1  head of sorted array available.
- out_ready  input  1  consumer accepts the head word.
- out_data  output  WIDTH  current head (cell 0).
- count  output  CNT_W  number of valid cells.
- sorted_flat  output  DEPTH*WIDTH  cell k at [k*WIDTH +: WIDTH]; invalid cells read 0.
- sorted_vld  output  DEPTH  per-cell valid mask (thermometer, LSB first).

Behaviour:
- Reset (rst=0, asynchronous): all cells and valid bits 0, count=0, state FILL, mode_q=0. Outputs: out_valid=0, out_data=0, sorted_flat=0, sorted_vld=0.
- States: FILL, DRAIN.
- in_ready = en & (state==FILL) & (count<DEPTH). This is combinational; in_valid does not feed in_ready.
- Accept: in_valid & in_ready.
  - The word is inserted in the same cycle; it is visible in sorted_flat the next cycle (latency 1).
  - mode_q is loaded from mode on an accept when count==0. mode changes mid-batch are ignored.
- Insertion compare per cell i: c[i] = ~vld[i] | (mode_q ? in_data > d[i] : in_data < d[i]), with strict compare.
  - Cell i loads in_data if c[i] & ~c[i-1] (c[-1]=0).
  - Cell i loads d[i-1] if c[i-1].
  - Otherwise cell i holds.
- Ties are stable: a new equal word lands after existing equal words.
- FILL→DRAIN transitions:
  - Taken when an accept makes count==DEPTH.
  - Also taken on flush while en=1 and count>0 (flush has priority over a same-cycle accept; that accept is blocked since in_ready stays as computed, so the bench must not assert both).
  - flush with count==0 is ignored.
- DRAIN:
  - out_valid = en & (count>0).
  - On out_valid & out_ready, all cells shift toward cell 0, the top cell clears, and count decrements.
  - The last handshake (count 1→0) returns to FILL. in_ready can rise the next cycle.
- out_valid=0 in FILL. out_data always shows cell 0.
- en=0: no accept, no shift, no transition; contents are held. flush is ignored while en=0.
- Reset mid-operation clears everything immediately; no partial data survives.

Optional Feature:
- SORTER_DEDUP_EN, when defined:
  - An accepted word equal to any valid cell is discarded; the array and count are unchanged.
  - A WIDTH-bit saturating output port dup_cnt counts discards. It resets to 0 and is cleared on DRAIN→FILL.
- When undefined: duplicates are stored per the tie rule, and the dup_cnt port is absent.

Decomposition:
- Package sorter_pkg: state encoding (FILL=1'b0, DRAIN=1'b1), MODE_ASC=0 / MODE_DESC=1 constants.
- Sub-module sort_cell: one WIDTH register plus valid bit, with compare output c and a load-select mux (hold/new/neighbour/shift).
- The top generates DEPTH instances and owns the FSM and counter.

Test Plan:
- DEPTH=16, WIDTH=32, mode=0. Stream 15,14,…,0, out_ready=1.
  - After 16 accepts: state DRAIN, in_ready=0, sorted_vld=16'hFFFF.
  - Drain yields out_data 0,1,…,15 on consecutive cycles; then in_ready=1.
- mode=1, stream 0..15 counting (as the stimulus counter produces) → drain 15 down to 0. A mode toggle mid-fill has no effect.
- Boundary: feed 32'hFFFFFFFF, 0, 32'h80000000, 32'hFFFFFFFF, then flush at count=4 → drain 0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF. Stalling out_ready=0 for 3 cycles holds out_data and count.
- Feed 5 words, toggle en=0 for 4 cycles with in_valid=1, then assert rst=0 mid-drain → nothing accepted while en=0. After reset, count=0, out_valid=0, sorted_flat=0 asynchronously.
- With SORTER_DEDUP_EN defined, feed 7,3,7,7,1 and flush → drain 1,3,7; dup_cnt=2 before the last handshake, 0 after.
